// File: rtl/sr_lsu.sv
// Load/store unit bridging the core's data-memory controls to a req/gnt/rvalid word bus.
// Optional misaligned-access trap enabled by defining SR_LSU_MISALIGN_TRAP_EN.
module sr_lsu #(
  parameter int unsigned SR_LSU_AW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dmWe,
  input  logic                 dmRe,
  input  logic                 dmSign,
  input  logic                 dmOpByte,
  input  logic                 dmOpHalf,
  input  logic                 dmOpWord,
  input  logic [SR_LSU_AW-1:0] dmAddr,
  input  logic [31:0]          dmWData,
  output logic [31:0]          dmRData,
  output logic                 lsuStall,
  output logic                 lsuMisalign,
  output logic                 busReq,
  input  logic                 busGnt,
  output logic                 busWe,
  output logic [SR_LSU_AW-1:0] busAddr,
  output logic [3:0]           busBe,
  output logic [31:0]          busWData,
  input  logic                 busRValid,
  input  logic [31:0]          busRData
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                 r_state;
  logic                   r_bus_req;
  logic                   r_bus_we;
  logic [SR_LSU_AW-1:0]   r_bus_addr;
  logic [3:0]             r_bus_be;
  logic [31:0]            r_bus_wdata;
  logic [31:0]            r_rdata;
  logic                   r_misalign;
  logic [1:0]             r_off;
  logic [1:0]             r_size;
  logic                   r_sign;

  logic                   w_mem_op;
  logic                   w_trap;
  logic [1:0]             w_size;
  logic [1:0]             w_off;
  logic [3:0]             w_be;
  logic [31:0]            w_wdata;
  logic [31:0]            w_shifted;
  logic [31:0]            w_ld_ext;

  assign w_mem_op = dmWe | dmRe;

  // Request decode: size priority word > half > byte, lane offset and replicated data.
  always_comb begin
    w_size  = SZ_WORD;
    w_off   = 2'b00;
    w_be    = 4'b0000;
    w_wdata = dmWData;
    if (dmOpWord) begin
      w_be = 4'b1111;
    end else if (dmOpHalf) begin
      w_size  = SZ_HALF;
      w_off   = {dmAddr[1], 1'b0};
      w_be    = 4'b0011 << w_off;
      w_wdata = {2{dmWData[15:0]}};
    end else if (dmOpByte) begin
      w_size  = SZ_BYTE;
      w_off   = dmAddr[1:0];
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{dmWData[7:0]}};
    end
  end

`ifdef SR_LSU_MISALIGN_TRAP_EN
  assign w_trap = (dmOpWord & (dmAddr[1:0] != 2'b00)) |
                  (~dmOpWord & dmOpHalf & dmAddr[0]);
`else
  assign w_trap = 1'b0;
`endif

  // Align the returned word to the captured lane offset, then extend to 32 bits.
  always_comb begin
    w_shifted = busRData >> {r_off, 3'b000};
    case (r_size)
      SZ_BYTE: w_ld_ext = {{24{r_sign & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_ld_ext = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ld_ext = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0;
      r_rdata     <= 32'h0;
      r_misalign  <= 1'b0;
      r_off       <= 2'b00;
      r_size      <= SZ_WORD;
      r_sign      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            if (w_trap) begin
              r_state    <= DONE;
              r_misalign <= 1'b1;
              if (!dmWe) r_rdata <= 32'h0;
            end else begin
              r_state     <= REQ;
              r_bus_req   <= 1'b1;
              r_bus_we    <= dmWe;
              r_bus_addr  <= {dmAddr[SR_LSU_AW-1:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
              r_off       <= w_off;
              r_size      <= w_size;
              r_sign      <= dmSign;
            end
          end
        end
        REQ: begin
          if (busGnt) begin
            r_bus_req <= 1'b0;
            r_state   <= r_bus_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (busRValid) begin
            r_rdata <= w_ld_ext;
            r_state <= DONE;
          end
        end
        default: begin
          r_misalign <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the core holds PC in the very cycle the op is decoded.
  assign lsuStall    = w_mem_op & (r_state != DONE);
  assign lsuMisalign = r_misalign;
  assign busReq      = r_bus_req;
  assign busWe       = r_bus_we;
  assign busAddr     = r_bus_addr;
  assign busBe       = r_bus_be;
  assign busWData    = r_bus_wdata;
  assign dmRData     = r_rdata;

endmodule
